load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access per instruction, with byte-lane
// steering for stores, sign/zero extension for loads and a bounded wait for MemAck.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; illegal or misaligned requests fault straight to DONE
// BUSY  | request held on the memory port until MemAck or the wait counter hits TIMEOUT
// DONE  | one-cycle completion pulse, Err reports fault/timeout
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemBe,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic [31:0] LoadData,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt, cnt_inc;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q, err_nxt;
  logic [31:0] load_q, load_nxt;
  logic        latch_en;
  logic        req_any, f3_ok, aligned, access_ok, busy;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req_any = MemRead | MemWrite;
  assign cnt_inc = wait_cnt + 8'd1;
  assign busy    = (state == BUSY);

  // Unsigned widths exist only for loads.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (Funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = MemRead;
      default:                f3_ok = 1'b0;
    endcase
    if (Funct3[1:0] == 2'b01)      aligned = ~Addr[0];
    else if (Funct3[1:0] == 2'b10) aligned = (Addr[1:0] == 2'b00);
    access_ok = (MemRead ^ MemWrite) & f3_ok & aligned;
  end

  always_comb begin
    ld_byte = MemRdata[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = MemRdata[15:8];
      2'd2:    ld_byte = MemRdata[23:16];
      2'd3:    ld_byte = MemRdata[31:24];
      default: ld_byte = MemRdata[7:0];
    endcase
    ld_half = addr_q[1] ? MemRdata[31:16] : MemRdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = MemRdata;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_q;
    load_nxt     = load_q;
    latch_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (access_ok) begin
            latch_en     = 1'b1;
            wait_cnt_nxt = 8'd0;
            state_nxt    = BUSY;
          end else begin
            err_nxt   = 1'b1;
            load_nxt  = 32'd0;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        if (MemAck) begin
          err_nxt   = 1'b0;
          if (!we_q) load_nxt = ld_ext;
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            err_nxt   = 1'b1;
            load_nxt  = 32'd0;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      load_q   <= 32'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_q    <= err_nxt;
      load_q   <= load_nxt;
      if (latch_en) begin
        addr_q   <= Addr;
        wdata_q  <= WriteData;
        funct3_q <= Funct3;
        we_q     <= MemWrite;
      end
    end
  end

  // Memory port is driven only in BUSY, so reset and idle both present zeros.
  always_comb begin
    MemReq   = busy;
    MemWe    = busy & we_q;
    MemAddr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    MemBe    = 4'd0;
    MemWdata = 32'd0;
    if (busy) begin
      MemBe = 4'b1111;
      if (we_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            MemBe    = 4'b0001 << addr_q[1:0];
            MemWdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            MemBe    = addr_q[1] ? 4'b1100 : 4'b0011;
            MemWdata = {2{wdata_q[15:0]}};
          end
          default: MemWdata = wdata_q;
        endcase
      end
    end
  end

  assign Stall    = busy | ((state == IDLE) & req_any);
  assign Done     = (state == DONE);
  assign Err      = err_q;
  assign LoadData = load_q;

endmodule
